// File: rtl/slope_ctrl.sv
// Peak-driven period measurement sequencer for the sine/cos generator and slope detector.
// Define SLOPE_CTRL_MINMAX_EN to track signed sample extremes; otherwise peak_max/peak_min read 0.
module slope_ctrl #(
  parameter int WIDTH  = 16,
  parameter int CNT_W  = 24,
  parameter int SETTLE = 4,
  parameter int TMO_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [7:0]       i_n_cycles,
  input  logic [WIDTH-1:0] i_datain,
  input  logic             i_gt,
  input  logic             i_lt,
  input  logic             i_eq,
  output logic             o_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [CNT_W-1:0] o_period,
  output logic [WIDTH-1:0] o_peak_max,
  output logic [WIDTH-1:0] o_peak_min
);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SEEK, S_MEASURE, S_DONE} state_t;
  typedef enum logic [1:0] {D_NONE, D_RISE, D_FALL} dir_t;

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           r_state, w_state_nxt;
  dir_t             r_dir;
  logic [SW-1:0]    r_set_cnt;
  logic [TMO_W-1:0] r_tmo;
  logic [CNT_W-1:0] r_cnt, r_period, w_cnt_inc;
  logic [7:0]       r_remain;
  logic             r_err;
  logic             w_rise, w_fall, w_peak, w_tmo_exp, w_accept, w_track;

  assign w_rise    = i_gt & ~i_lt & ~i_eq;
  assign w_fall    = i_lt & ~i_gt & ~i_eq;
  assign w_peak    = w_fall && (r_dir == D_RISE);
  assign w_tmo_exp = (r_tmo == TMO_LAST);
  assign w_accept  = (r_state == S_IDLE) & i_start & ~i_abort;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_track   = (r_state == S_SETTLE) || (r_state == S_SEEK) || (r_state == S_MEASURE);

  always_comb begin
    w_state_nxt = r_state;
    o_en        = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        o_en = 1'b1;
        if (r_set_cnt == SW'(SETTLE - 1)) w_state_nxt = S_SEEK;
      end
      S_SEEK: begin
        o_en = 1'b1;
        if (w_peak)         w_state_nxt = S_MEASURE;
        else if (w_tmo_exp) w_state_nxt = S_DONE;
      end
      S_MEASURE: begin
        o_en = 1'b1;
        if (w_peak && r_remain == 8'd1) w_state_nxt = S_DONE;
        else if (!w_peak && w_tmo_exp)  w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_dir     <= D_NONE;
      r_set_cnt <= '0;
      r_tmo     <= '0;
      r_cnt     <= '0;
      r_period  <= '0;
      r_remain  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept)    r_dir <= D_NONE;
      else if (w_rise) r_dir <= D_RISE;
      else if (w_fall) r_dir <= D_FALL;

      if (w_accept) begin
        r_remain  <= (i_n_cycles == 8'd0) ? 8'd1 : i_n_cycles;
        r_period  <= '0;
        r_err     <= 1'b0;
        r_set_cnt <= '0;
        r_tmo     <= '0;
      end else if (!i_abort) begin
        case (r_state)
          S_SETTLE: r_set_cnt <= r_set_cnt + SW'(1);
          S_SEEK: begin
            if (w_peak) begin
              r_cnt <= '0;
              r_tmo <= '0;
            end else begin
              r_tmo <= r_tmo + TMO_W'(1);
              if (w_tmo_exp) r_err <= 1'b1;
            end
          end
          S_MEASURE: begin
            r_cnt <= w_cnt_inc;
            if (w_peak) begin
              // A peak coinciding with timeout expiry still counts and restarts the timeout.
              r_remain <= r_remain - 8'd1;
              r_tmo    <= '0;
              if (r_remain == 8'd1) r_period <= w_cnt_inc;
            end else begin
              r_tmo <= r_tmo + TMO_W'(1);
              if (w_tmo_exp) r_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_err    = r_err;
  assign o_period = r_period;

`ifdef SLOPE_CTRL_MINMAX_EN
  logic signed [WIDTH-1:0] r_max, r_min;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_max <= '0;
      r_min <= '0;
    end else if (w_accept) begin
      r_max <= {1'b1, {(WIDTH-1){1'b0}}};
      r_min <= {1'b0, {(WIDTH-1){1'b1}}};
    end else if (w_track && !i_abort) begin
      if ($signed(i_datain) > r_max) r_max <= $signed(i_datain);
      if ($signed(i_datain) < r_min) r_min <= $signed(i_datain);
    end
  end

  assign o_peak_max = r_max;
  assign o_peak_min = r_min;
`else
  logic w_unused_dat;
  assign w_unused_dat = ^{i_datain, w_track};
  assign o_peak_max   = '0;
  assign o_peak_min   = '0;
`endif

endmodule

// File: tb/tb_slope_ctrl.sv
// Randomized bench for slope_ctrl: drives sample/flag streams and compares against an event-list model.
module tb_slope_ctrl;
  localparam int SETTLE = 4;
  localparam int TMO_W  = 6;
  localparam int TMO    = (1 << TMO_W) - 1;
  localparam int LEN    = 400;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic        gt = 1'b0, lt = 1'b0, eq = 1'b0;
  logic [7:0]  n_cycles = 8'd0;
  logic [15:0] datain = 16'd0;
  logic        en, busy, done, err;
  logic [23:0] period;
  logic [15:0] pmax, pmin;

  int tests = 0, fails = 0;
  int sx[LEN];
  bit sg[LEN], sl[LEN], se[LEN];
  int exp_d, exp_err, exp_period, exp_max, exp_min;
  int obs_d, n_done;
  logic obs_err;
  logic [23:0] obs_period;
  logic [15:0] obs_max, obs_min;

  slope_ctrl #(.WIDTH(16), .CNT_W(24), .SETTLE(SETTLE), .TMO_W(TMO_W)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_abort(abort),
    .i_n_cycles(n_cycles), .i_datain(datain), .i_gt(gt), .i_lt(lt), .i_eq(eq),
    .o_en(en), .o_busy(busy), .o_done(done), .o_err(err), .o_period(period),
    .o_peak_max(pmax), .o_peak_min(pmin)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic flags_from_samples(input int noise_pct);
    sg[0] = 0; sl[0] = 0; se[0] = 0;
    for (int t = 1; t < LEN; t++) begin
      sg[t] = sx[t] > sx[t-1];
      sl[t] = sx[t] < sx[t-1];
      se[t] = sx[t] == sx[t-1];
      if (int'($urandom_range(99)) < noise_pct) begin
        sg[t] = 1; sl[t] = 1; se[t] = 0;
      end
    end
  endtask

  // Triangle from -amp rising, with plat extra repeats at each extreme.
  task automatic gen_tri(input int amp, input int step, input int plat, input int phase, input int noise_pct);
    int pat[$];
    int k;
    k = 2 * amp / step;
    for (int i = 0; i < k; i++) pat.push_back(-amp + i * step);
    for (int i = 0; i <= plat; i++) pat.push_back(amp);
    for (int i = 1; i < k; i++) pat.push_back(amp - i * step);
    for (int i = 0; i < plat; i++) pat.push_back(-amp);
    for (int t = 0; t < LEN; t++) sx[t] = pat[(t + phase) % pat.size()];
    flags_from_samples(noise_pct);
  endtask

  task automatic gen_flat();
    for (int t = 0; t < LEN; t++) sx[t] = 0;
    flags_from_samples(0);
  endtask

  // Reference: walk the edge stream (edge 0 = start), list peak events, apply count/timeout rules.
  task automatic model(input int n);
    int dir, last, rem, p0;
    bit seeking, pk;
    dir = 0; last = SETTLE; rem = (n == 0) ? 1 : n; seeking = 1; p0 = 0;
    exp_max = -32768; exp_min = 32767; exp_d = -1; exp_err = 0; exp_period = 0;
    for (int t = 1; t < LEN; t++) begin
      pk = sl[t] && !sg[t] && !se[t] && dir == 1;
      if (sx[t] > exp_max) exp_max = sx[t];
      if (sx[t] < exp_min) exp_min = sx[t];
      if (sg[t] && !sl[t] && !se[t]) dir = 1;
      else if (sl[t] && !sg[t] && !se[t]) dir = 2;
      if (t > SETTLE) begin
        if (pk) begin
          last = t;
          if (seeking) begin
            seeking = 0; p0 = t;
          end else begin
            rem--;
            if (rem == 0) begin exp_d = t; exp_period = t - p0; return; end
          end
        end else if (t - last == TMO) begin
          exp_d = t; exp_err = 1; return;
        end
      end
    end
  endtask

  task automatic run(input int n, input int abort_at, input int stray_at, input int n_after);
    int limit;
    model(n);
    limit = (abort_at >= 0) ? abort_at + 12 : exp_d + 3;
    obs_d = -1; n_done = 0;
    for (int t = 0; t <= limit; t++) begin
      datain = 16'(sx[t]); gt = sg[t]; lt = sl[t]; eq = se[t];
      start = (t == 0) || (t == stray_at);
      abort = (t == abort_at);
      n_cycles = (t == 0) ? 8'(n) : 8'(n_after);
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        if (obs_d < 0) begin
          obs_d = t; obs_err = err; obs_period = period; obs_max = pmax; obs_min = pmin;
        end
      end
      if (t == 0) begin
        tests++;
        if (busy !== 1'b1 || en !== 1'b1) begin
          fails++; $display("FAIL start_busy_en: busy=%b en=%b, want 1 1", busy, en);
        end
      end
      if (t == abort_at) begin
        tests++;
        if (en !== 1'b0 || busy !== 1'b0) begin
          fails++; $display("FAIL abort_idle: en=%b busy=%b, want 0 0", en, busy);
        end
      end
      if (abort_at < 0 && t == exp_d + 1) begin
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          fails++; $display("FAIL done_one_cycle: done=%b busy=%b after done, want 0 0", done, busy);
        end
      end
    end
    start = 0; abort = 0;
  endtask

  task automatic check_result(input string nm, input int want_d, input int want_err, input int want_period,
                              input int want_max, input int want_min);
    tests++;
    if (obs_d !== want_d || n_done !== 1) begin
      fails++; $display("FAIL %s_done: done at edge %0d (%0d pulses), want edge %0d (1 pulse)", nm, obs_d, n_done, want_d);
    end
    tests++;
    if (obs_err !== want_err[0] || obs_period !== 24'(want_period)) begin
      fails++; $display("FAIL %s_result: err=%b period=%0d, want err=%0d period=%0d", nm, obs_err, obs_period, want_err, want_period);
    end
    tests++;
`ifdef SLOPE_CTRL_MINMAX_EN
    if (obs_max !== 16'(want_max) || obs_min !== 16'(want_min)) begin
      fails++; $display("FAIL %s_minmax: max=%0d min=%0d, want %0d %0d", nm, $signed(obs_max), $signed(obs_min), want_max, want_min);
    end
`else
    if (obs_max !== 16'd0 || obs_min !== 16'd0 || want_max == want_min - 1) begin
      fails++; $display("FAIL %s_minmax: max=%0d min=%0d, want 0 0", nm, $signed(obs_max), $signed(obs_min));
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({en, busy, done, err} !== 4'b0 || period !== 24'd0 || pmax !== 16'd0 || pmin !== 16'd0) begin
      fails++; $display("FAIL reset_values: en=%b busy=%b done=%b err=%b period=%0d max=%0d min=%0d, want all 0",
                        en, busy, done, err, period, pmax, pmin);
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    gen_tri(100, 10, 0, 0, 0);
    run(3, -1, -1, 3);
    check_result("basic", exp_d, 0, 120, 100, -100);
  endtask

  task automatic test_zero_count();
    gen_tri(100, 10, 0, 0, 0);
    run(0, -1, -1, 0);
    check_result("zero_count", exp_d, 0, 40, 100, -100);
  endtask

  task automatic test_plateau();
    gen_tri(100, 10, 3, 0, 0);
    run(2, -1, -1, 2);
    check_result("plateau", exp_d, 0, 92, 100, -100);
  endtask

  task automatic test_timeout();
    gen_flat();
    run(3, -1, -1, 3);
    check_result("timeout", SETTLE + TMO, 1, 0, 0, 0);
  endtask

  task automatic test_abort_stray();
    gen_tri(100, 10, 0, 0, 0);
    run(3, -1, 50, 7);
    check_result("stray_start", exp_d, 0, 120, 100, -100);
    run(3, 100, -1, 3);
    tests++;
    if (n_done !== 0 || busy !== 1'b0 || period !== 24'd0) begin
      fails++; $display("FAIL abort_no_done: done pulses=%0d busy=%b period=%0d, want 0 0 0", n_done, busy, period);
    end
  endtask

  task automatic test_async_reset();
    gen_tri(100, 10, 0, 0, 0);
    for (int t = 0; t < 60; t++) begin
      datain = 16'(sx[t]); gt = sg[t]; lt = sl[t]; eq = se[t];
      start = (t == 0); n_cycles = 8'd3;
      @(posedge clk); #1;
    end
    start = 0;
    tests++;
    if (busy !== 1'b1 || en !== 1'b1) begin
      fails++; $display("FAIL pre_reset_busy: busy=%b en=%b, want 1 1", busy, en);
    end
    #3 rst_n = 0;
    #1;
    tests++;
    if ({en, busy, done, err} !== 4'b0 || period !== 24'd0 || pmax !== 16'd0 || pmin !== 16'd0) begin
      fails++; $display("FAIL async_reset: en=%b busy=%b done=%b err=%b period=%0d max=%0d min=%0d, want all 0",
                        en, busy, done, err, period, pmax, pmin);
    end
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    run(3, -1, -1, 3);
    check_result("after_reset", exp_d, 0, 120, 100, -100);
  endtask

  task automatic test_random();
    int step, m, plat, per, n;
    for (int it = 0; it < 10; it++) begin
      step = $urandom_range(1, 50);
      m    = $urandom_range(1, 7);
      plat = $urandom_range(0, 3);
      per  = 4 * m + 2 * plat;
      n    = $urandom_range(0, 4);
      gen_tri(step * m, step, plat, $urandom_range(0, per - 1), 5);
      run(n, -1, -1, $urandom_range(0, 255));
      check_result($sformatf("random%0d", it), exp_d, exp_err, exp_period, exp_max, exp_min);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_plateau();
    test_timeout();
    test_abort_stray();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
